// File: rtl/dco_phase_trim_ctrl.sv
// rtl/dco_phase_trim_ctrl.sv - DCO phase generator with ramped thermometer trim control
module dco_phase_trim_ctrl #(
  parameter int NSTAGES = 13,
  parameter int NPHASE  = 2,
  parameter int SETTLE  = 4,
  localparam int CW     = $clog2(2*NSTAGES+1)
) (
  input  logic                 hiclock,
  input  logic                 ireset,
  input  logic                 enable,
  input  logic                 dco,
  input  logic [CW-1:0]        trim_code,
  input  logic [2*NSTAGES-1:0] ext_trim,
  output logic [NPHASE-1:0]    clockp,
  output logic [2*NSTAGES-1:0] itrim,
  output logic [CW-1:0]        cur_code,
  output logic                 settled
);

  localparam int TW = 2*NSTAGES;
  localparam logic [CW-1:0] MAX_CODE = CW'(TW);
  localparam logic [3:0]    SETTLE_C = 4'(SETTLE);

  logic [NPHASE-1:0] j_q, j_d, j_shift;
  logic [CW-1:0]     cur_q, cur_d;
  logic [TW-1:0]     itrim_q, itrim_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              settled_q, settled_d;
  logic [CW-1:0]     target;
  logic              ps;

  // Johnson shift; a single phase degenerates to a toggle
  generate
    if (NPHASE == 1) begin : g_one_phase
      assign j_shift = ~j_q;
    end else begin : g_multi_phase
      assign j_shift = {j_q[NPHASE-2:0], ~j_q[NPHASE-1]};
    end
  endgenerate

  // Period start: the phase counter is at its all-zero state while running
  assign ps     = enable && (j_q == '0);
  assign target = (trim_code > MAX_CODE) ? MAX_CODE : trim_code;

  // Phase counter next state: run while enabled, park at zero otherwise
  always_comb begin
    j_d = '0;
    if (enable) begin
      j_d = j_shift;
    end
  end

  // Trim / settle next state, only ever changing at a period start
  always_comb begin
    cur_d     = cur_q;
    itrim_d   = itrim_q;
    cnt_d     = cnt_q;
    settled_d = settled_q;
    if (ps) begin
      if (dco) begin
        itrim_d   = ext_trim;
        cnt_d     = 4'd0;
        settled_d = 1'b0;
      end else begin
        if (cur_q < target) begin
          cur_d = cur_q + CW'(1);
          cnt_d = 4'd0;
        end else if (cur_q > target) begin
          cur_d = cur_q - CW'(1);
          cnt_d = 4'd0;
        end else if (cnt_q < SETTLE_C) begin
          cnt_d = cnt_q + 4'd1;
        end
        // Thermometer of the new code: primary stages fill before secondary
        for (int k = 0; k < TW; k++) begin
          itrim_d[k] = (k < int'(cur_d));
        end
        settled_d = (cnt_d == SETTLE_C);
      end
    end
  end

  // State registers with asynchronous clear so reset zeroes outputs immediately
  always_ff @(posedge hiclock or posedge ireset) begin
    if (ireset) begin
      j_q       <= '0;
      cur_q     <= '0;
      itrim_q   <= '0;
      cnt_q     <= 4'd0;
      settled_q <= 1'b0;
    end else begin
      j_q       <= j_d;
      cur_q     <= cur_d;
      itrim_q   <= itrim_d;
      cnt_q     <= cnt_d;
      settled_q <= settled_d;
    end
  end

  assign clockp   = j_q;
  assign itrim    = itrim_q;
  assign cur_code = cur_q;
  assign settled  = settled_q;

endmodule
